ahblite_lcd8080_ctrl: RTL and testbench

//  AHB-Lite slave that drives an 8080-style parallel LCD with hardware write-strobe timing.

---
 rtl/ahblite_lcd8080_ctrl_if.sv | 24 ++
 rtl/ahblite_lcd8080_ctrl.sv | 172 +++++++++++++++++
 tb/tb_ahblite_lcd8080_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ahblite_lcd8080_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the 8080 LCD controller.
interface ahblite_lcd8080_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRDATA, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRDATA, HRESP
    );
endinterface

// File: rtl/ahblite_lcd8080_ctrl.sv
// AHB-Lite slave feeding a write FIFO that a strobe FSM drains onto an 8080-style LCD bus.
module ahblite_lcd8080_ctrl #(
    parameter int DATA_W      = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int WR_LOW_RST  = 2,
    parameter int WR_HIGH_RST = 2
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahblite_lcd8080_ctrl_if.slave ahb,
    output logic              LCD_CS,
    output logic              LCD_RS,
    output logic              LCD_WR,
    output logic              LCD_RD,
    output logic              LCD_RST,
    output logic              LCD_BL_CTR,
    output logic [DATA_W-1:0] LCD_DATA
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

    state_t          state, state_nxt;
    logic [2:0]      addr_q;
    logic            wr_q, sel_q;
    logic [2:0]      ctrl_q;
    logic [7:0]      wr_low, wr_high, cnt;
    logic            ovf;
    logic [DATA_W:0] mem [FIFO_DEPTH];
    logic [AW:0]     wptr, rptr, level;
    logic            full, empty, busy, en;
    logic            wr_en, push_req, push, pop, flush, load_low, load_high;
    logic [31:0]     rdata;
    logic            unused_ok;

    function automatic logic [7:0] nz(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    assign unused_ok = ^{ahb.HSIZE, ahb.HPROT, ahb.HADDR, ahb.HWDATA};

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sel_q  <= 1'b0;
            wr_q   <= 1'b0;
            addr_q <= '0;
        end else if (ahb.HREADY) begin
            sel_q  <= ahb.HSEL & ahb.HTRANS[1];
            wr_q   <= ahb.HWRITE;
            addr_q <= ahb.HADDR[4:2];
        end
    end

    assign wr_en    = sel_q & wr_q;
    assign push_req = wr_en & (addr_q == 3'd0 || addr_q == 3'd1);
    assign flush    = wr_en & (addr_q == 3'd2) & ahb.HWDATA[3];
    assign level    = wptr - rptr;
    assign full     = (level == FULL_LVL);
    assign empty    = (level == '0);
    // Full is judged before any same-cycle pop; flush takes priority over a push.
    assign push     = push_req & ~full & ~flush;
    assign en       = ctrl_q[2];
    assign busy     = (state != S_IDLE) | ~empty;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ctrl_q  <= '0;
            wr_low  <= 8'(WR_LOW_RST);
            wr_high <= 8'(WR_HIGH_RST);
            ovf     <= 1'b0;
        end else begin
            if (wr_en && addr_q == 3'd2) ctrl_q <= ahb.HWDATA[2:0];
            if (wr_en && addr_q == 3'd3) begin
                wr_low  <= ahb.HWDATA[7:0];
                wr_high <= ahb.HWDATA[15:8];
            end
            if (push_req && full && !flush) ovf <= 1'b1;
            else if (wr_en && addr_q == 3'd4 && ahb.HWDATA[3]) ovf <= 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (push) mem[wptr[AW-1:0]] <= {addr_q[0], ahb.HWDATA[DATA_W-1:0]};
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wptr <= '0;
            rptr <= '0;
        end else if (flush) begin
            rptr <= wptr;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        load_low  = 1'b0;
        load_high = 1'b0;
        case (state)
            S_IDLE: if (en && !empty) begin
                state_nxt = S_LOW;
                pop       = 1'b1;
                load_low  = 1'b1;
            end
            S_LOW: if (cnt <= 8'd1) begin
                state_nxt = S_HIGH;
                load_high = 1'b1;
            end
            S_HIGH: if (cnt <= 8'd1) begin
                if (en && !empty) begin
                    state_nxt = S_LOW;
                    pop       = 1'b1;
                    load_low  = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        LCD_CS = (state == S_IDLE);
        LCD_WR = (state != S_LOW);
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cnt      <= '0;
            LCD_RS   <= 1'b0;
            LCD_DATA <= '0;
        end else begin
            if (load_low)       cnt <= nz(wr_low);
            else if (load_high) cnt <= nz(wr_high);
            else if (cnt != 8'd0) cnt <= cnt - 8'd1;
            if (pop) {LCD_RS, LCD_DATA} <= mem[rptr[AW-1:0]];
        end
    end

    always_comb begin
        rdata = '0;
        case (addr_q)
            3'd2: rdata[2:0]  = ctrl_q;
            3'd3: rdata[15:0] = {wr_high, wr_low};
            3'd4: begin
                rdata[0]    = busy;
                rdata[1]    = full;
                rdata[2]    = empty;
                rdata[3]    = ovf;
                rdata[15:8] = 8'(level);
            end
            default: rdata = '0;
        endcase
    end

    assign ahb.HRDATA    = rdata;
    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;
    assign LCD_RD        = 1'b1;
    assign LCD_RST       = ctrl_q[0];
    assign LCD_BL_CTR    = ctrl_q[1];
endmodule

// File: tb/tb_ahblite_lcd8080_ctrl.sv
// Scoreboard bench: bus tasks queue expected strobes/reads, monitors compare on LCD_WR edges and read data phases.
module tb_ahblite_lcd8080_ctrl;
    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        LCD_CS, LCD_RS, LCD_WR, LCD_RD, LCD_RST, LCD_BL_CTR;
    logic [15:0] LCD_DATA;

    ahblite_lcd8080_ctrl_if ahb();
    assign ahb.HREADY = ahb.HREADYOUT;

    ahblite_lcd8080_ctrl #(
        .DATA_W(16), .FIFO_DEPTH(8), .WR_LOW_RST(2), .WR_HIGH_RST(2)
    ) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .ahb(ahb),
        .LCD_CS(LCD_CS), .LCD_RS(LCD_RS), .LCD_WR(LCD_WR), .LCD_RD(LCD_RD),
        .LCD_RST(LCD_RST), .LCD_BL_CTR(LCD_BL_CTR), .LCD_DATA(LCD_DATA)
    );

    always #5 HCLK = ~HCLK;

    typedef struct { logic rs; logic [15:0] data; int lo; int hi; } strobe_t;
    typedef struct { logic [31:0] exp; string name; } rd_t;

    strobe_t sq[$];
    rd_t     rq[$];
    int      nchecks = 0, nerr = 0;
    int      cur_lo = 2, cur_hi = 2;
    logic    rd_dphase = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        ahb.HSEL = 1'b0; ahb.HTRANS = 2'b00; ahb.HWRITE = 1'b0;
    endtask

    task automatic bus_addr(input logic [31:0] a, input logic w);
        @(posedge HCLK); #1;
        ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HADDR = a; ahb.HWRITE = w;
        ahb.HSIZE = 3'b010; ahb.HPROT = 4'b0011;
    endtask

    task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
        bus_addr(a, 1'b1);
        @(posedge HCLK); #1;
        bus_idle();
        ahb.HWDATA = d;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read_raw(input logic [31:0] a, output logic [31:0] d);
        bus_addr(a, 1'b0);
        @(posedge HCLK); #1;
        bus_idle();
        @(negedge HCLK);
        d = ahb.HRDATA;
        @(posedge HCLK); #1;
    endtask

    task automatic ahb_read_chk(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus_addr(a, 1'b0);
        @(posedge HCLK); #1;
        bus_idle();
        rq.push_back('{exp, name});
        rd_dphase = 1'b1;
        @(posedge HCLK); #1;
        rd_dphase = 1'b0;
    endtask

    task automatic push_word(input logic rs, input logic [15:0] d, input logic expect_strobe);
        if (expect_strobe) sq.push_back('{rs, d, cur_lo, cur_hi});
        ahb_write(rs ? 32'h4 : 32'h0, {16'h0, d});
    endtask

    task automatic set_timing(input int lo, input int hi);
        ahb_write(32'hC, {16'h0, hi[7:0], lo[7:0]});
        cur_lo = (lo == 0) ? 1 : lo;
        cur_hi = (hi == 0) ? 1 : hi;
    endtask

    task automatic wait_idle();
        logic [31:0] s;
        s = 32'h1;
        for (int i = 0; i < 60; i++) begin
            ahb_read_raw(32'h10, s);
            if (!s[0]) break;
        end
        chk("idle_reached", {31'h0, s[0]}, 32'h0);
    endtask

    // Read-data monitor
    always @(negedge HCLK) begin
        if (rd_dphase) begin
            if (rq.size() == 0) begin
                nchecks++; nerr++;
                $display("FAIL read_unexpected: got 0x%0h expected none", ahb.HRDATA);
            end else begin
                rd_t r;
                r = rq.pop_front();
                chk(r.name, ahb.HRDATA, r.exp);
            end
        end
    end

    // Strobe monitor: measures WR low/high widths and latches RS/DATA at the WR rising edge
    logic    prev_wr = 1'b1, in_high = 1'b0;
    int      low_cnt = 0, high_cnt = 0, pend_hi = 0;
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            prev_wr = 1'b1; in_high = 1'b0; low_cnt = 0; high_cnt = 0;
        end else begin
            if (!LCD_WR) begin
                if (prev_wr) begin
                    if (in_high) begin
                        chk("wr_high_cycles", high_cnt, pend_hi);
                        in_high = 1'b0;
                    end
                    low_cnt = 0;
                end
                low_cnt++;
                chk("cs_low_during_wr", {31'h0, LCD_CS}, 32'h0);
            end else if (!prev_wr) begin
                if (sq.size() == 0) begin
                    nchecks++; nerr++;
                    $display("FAIL strobe_unexpected: got data 0x%0h expected no strobe", LCD_DATA);
                end else begin
                    strobe_t e;
                    e = sq.pop_front();
                    chk("strobe_rs", {31'h0, LCD_RS}, {31'h0, e.rs});
                    chk("strobe_data", {16'h0, LCD_DATA}, {16'h0, e.data});
                    chk("wr_low_cycles", low_cnt, e.lo);
                    pend_hi = e.hi;
                    in_high = 1'b1;
                    high_cnt = 1;
                end
            end else if (in_high) begin
                if (!LCD_CS) high_cnt++;
                else begin
                    chk("wr_high_cycles", high_cnt, pend_hi);
                    in_high = 1'b0;
                end
            end
            prev_wr = LCD_WR;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ahb.HADDR = '0; ahb.HWDATA = '0; ahb.HSIZE = 3'b010; ahb.HPROT = 4'b0011;
        bus_idle();

        // 1: reset values
        #12;
        chk("rst_cs",   {31'h0, LCD_CS},     32'h1);
        chk("rst_wr",   {31'h0, LCD_WR},     32'h1);
        chk("rst_rd",   {31'h0, LCD_RD},     32'h1);
        chk("rst_rs",   {31'h0, LCD_RS},     32'h0);
        chk("rst_data", {16'h0, LCD_DATA},   32'h0);
        chk("rst_lrst", {31'h0, LCD_RST},    32'h0);
        chk("rst_bl",   {31'h0, LCD_BL_CTR}, 32'h0);
        @(negedge HCLK); HRESETn = 1'b1;
        ahb_read_chk(32'h10, 32'h0000_0004, "status_reset");
        ahb_read_chk(32'h0C, 32'h0000_0202, "timing_reset");
        ahb_read_chk(32'h08, 32'h0000_0000, "ctrl_reset");

        // 2: single command strobe, default timing
        ahb_write(32'h8, 32'h7);
        chk("lcd_rst_on", {31'h0, LCD_RST},    32'h1);
        chk("lcd_bl_on",  {31'h0, LCD_BL_CTR}, 32'h1);
        push_word(1'b0, 16'h002C, 1'b1);
        repeat (5) @(posedge HCLK);
        ahb_read_chk(32'h10, 32'h0000_0004, "status_idle_after_cmd");

        // 3: back-to-back data strobes, low 1 / high 3
        set_timing(1, 3);
        ahb_read_chk(32'h0C, 32'h0000_0301, "timing_readback");
        push_word(1'b1, 16'hF800, 1'b1);
        push_word(1'b1, 16'h07E0, 1'b1);
        push_word(1'b1, 16'h001F, 1'b1);
        wait_idle();

        // 4: fill past full with EN off, clear overflow, then drain
        ahb_write(32'h8, 32'h3);
        for (int i = 0; i < 9; i++) push_word(i[0], 16'h1000 + 16'(i), (i < 8) ? 1'b1 : 1'b0);
        ahb_read_chk(32'h10, 32'h0000_080B, "status_full_ovf");
        ahb_write(32'h10, 32'h8);
        ahb_read_chk(32'h10, 32'h0000_0803, "status_ovf_cleared");
        ahb_write(32'h8, 32'h7);
        wait_idle();
        ahb_read_chk(32'h10, 32'h0000_0004, "status_drained");

        // 5: flush mid-burst, then flush a full FIFO with overflow set
        ahb_write(32'h8, 32'h3);
        for (int i = 0; i < 6; i++) push_word(1'b1, 16'hA000 + 16'(i), (i == 0) ? 1'b1 : 1'b0);
        ahb_write(32'h8, 32'h7);
        ahb_write(32'h8, 32'hF);
        wait_idle();
        ahb_read_chk(32'h10, 32'h0000_0004, "status_after_flush");
        ahb_read_chk(32'h08, 32'h0000_0007, "ctrl_flush_selfclear");
        ahb_write(32'h8, 32'h3);
        for (int i = 0; i < 9; i++) push_word(1'b0, 16'h5500 + 16'(i), 1'b0);
        ahb_write(32'h8, 32'hB);
        ahb_read_chk(32'h10, 32'h0000_000C, "status_flush_keeps_ovf");
        ahb_write(32'h10, 32'h8);
        ahb_read_chk(32'h10, 32'h0000_0004, "status_ovf_w1c");

        // 6: asynchronous reset in the middle of a LOW phase
        set_timing(5, 5);
        ahb_write(32'h8, 32'h7);
        ahb_write(32'h0, 32'h1234);
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            if (!LCD_WR) break;
        end
        chk("wr_low_seen", {31'h0, LCD_WR}, 32'h0);
        #2 HRESETn = 1'b0;
        #1;
        chk("arst_wr",   {31'h0, LCD_WR},     32'h1);
        chk("arst_cs",   {31'h0, LCD_CS},     32'h1);
        chk("arst_data", {16'h0, LCD_DATA},   32'h0);
        chk("arst_lrst", {31'h0, LCD_RST},    32'h0);
        chk("arst_bl",   {31'h0, LCD_BL_CTR}, 32'h0);
        repeat (2) @(negedge HCLK);
        #1 HRESETn = 1'b1;
        cur_lo = 2; cur_hi = 2;
        ahb_read_chk(32'h10, 32'h0000_0004, "status_after_arst");
        ahb_read_chk(32'h0C, 32'h0000_0202, "timing_after_arst");
        ahb_read_chk(32'h08, 32'h0000_0000, "ctrl_after_arst");

        repeat (4) @(posedge HCLK);
        chk("strobe_queue_drained", sq.size(), 32'h0);
        chk("read_queue_drained",   rq.size(), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end
endmodule
